// File: rtl/vrf_pkg.sv
// Shared definitions for the VRF copy path: default widths and the copy FSM encoding.
package vrf_pkg;
  localparam int VRF_ADDR_WIDTH_DEF = 10;
  localparam int VRF_DATA_WIDTH_DEF = 1024;
  localparam int LEN_WIDTH_DEF      = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } vrf_copy_state_e;
endpackage

// File: rtl/vrf_copy_initiator.sv
// Copies cmd_len consecutive VRF words from cmd_src to cmd_dst through the
// arbiter router ports, one read/write pair per word.
module vrf_copy_initiator
  import vrf_pkg::*;
#(
  parameter int VRF_ADDR_WIDTH = VRF_ADDR_WIDTH_DEF,
  parameter int VRF_DATA_WIDTH = VRF_DATA_WIDTH_DEF,
  parameter int LEN_WIDTH      = LEN_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [VRF_ADDR_WIDTH-1:0] cmd_src,
  input  logic [VRF_ADDR_WIDTH-1:0] cmd_dst,
  input  logic [LEN_WIDTH-1:0]      cmd_len,
  output logic                      busy,
  output logic                      done,
  output logic [VRF_ADDR_WIDTH-1:0] src_addr,
  output logic                      read_req,
  input  logic                      read_gnt,
  input  logic [VRF_DATA_WIDTH-1:0] data_arbiter_send,
  output logic [VRF_ADDR_WIDTH-1:0] dst_addr,
  output logic [VRF_DATA_WIDTH-1:0] data_arbiter_recv,
  output logic                      write_req,
  input  logic                      write_gnt
);

  vrf_copy_state_e state, state_nx;

  logic [VRF_ADDR_WIDTH-1:0] src_q, dst_q;
  logic [LEN_WIDTH-1:0]      cnt_q;
  logic [VRF_DATA_WIDTH-1:0] data_q;

  logic accept, rd_fire, wr_fire;

  assign accept  = (state == IDLE) && cmd_valid;
  assign rd_fire = (state == RD) && read_gnt;
  assign wr_fire = (state == WR) && write_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cmd_valid) state_nx = (cmd_len == '0) ? DONE : RD;
      RD:   if (read_gnt) state_nx = WR;
      // cnt_q still holds the pre-decrement count on the write grant edge
      WR:   if (write_gnt) state_nx = (cnt_q == LEN_WIDTH'(1)) ? DONE : RD;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      if (accept) begin
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        cnt_q <= cmd_len;
      end
      if (rd_fire) data_q <= data_arbiter_send;
      // addresses wrap naturally at the VRF size
      if (wr_fire) begin
        src_q <= src_q + VRF_ADDR_WIDTH'(1);
        dst_q <= dst_q + VRF_ADDR_WIDTH'(1);
        cnt_q <= cnt_q - LEN_WIDTH'(1);
      end
    end
  end

  // Requests decode straight from the async-reset state so reset drops them at once.
  assign read_req          = (state == RD);
  assign write_req         = (state == WR);
  assign cmd_ready         = (state == IDLE);
  assign busy              = (state != IDLE);
  assign done              = (state == DONE);
  assign src_addr          = src_q;
  assign dst_addr          = dst_q;
  assign data_arbiter_recv = data_q;

endmodule
